// File: rtl/ra_stack_mctx_if.sv
// Bus bundle for the multi-context return-address stack: per-cycle op request,
// context select and the combinational/registered status returned by the stack.
interface ra_stack_mctx_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NCTX       = 4
);
  localparam int unsigned CTX_W = $clog2(NCTX);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  ena;
  logic [CTX_W-1:0]      ctx;
  logic                  push;
  logic                  pop;
  logic                  ret;
  logic [DATA_WIDTH-1:0] din;
  logic                  clr_mismatch;
  logic [DATA_WIDTH-1:0] dout;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  mismatch;
  logic [CTX_W-1:0]      mis_ctx;
  logic [DATA_WIDTH-1:0] mis_addr;
  logic                  ovf;
  logic                  udf;

  modport master (
    output ena, ctx, push, pop, ret, din, clr_mismatch,
    input  dout, count, full, empty, mismatch, mis_ctx, mis_addr, ovf, udf
  );

  modport slave (
    input  ena, ctx, push, pop, ret, din, clr_mismatch,
    output dout, count, full, empty, mismatch, mis_ctx, mis_addr, ovf, udf
  );
endinterface

// File: rtl/ra_stack_mctx.sv
// Multi-context return-address stack with sticky return-mismatch detection.
// Define RAS_OVF_WRAP_EN to make a push onto a full stack overwrite the oldest entry.
module ra_stack_mctx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned NCTX       = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  ra_stack_mctx_if.slave bus
);
  localparam int unsigned CTX_W = $clog2(NCTX);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_RET,
    OP_POP
  } op_e;

  logic [DATA_WIDTH-1:0] mem_q [NCTX][DEPTH];
  logic [PTR_W-1:0]      tp_q  [NCTX];
  logic [CNT_W-1:0]      cnt_q [NCTX];
  logic                  mismatch_q;
  logic [CTX_W-1:0]      mis_ctx_q;
  logic [DATA_WIDTH-1:0] mis_addr_q;
  logic                  ovf_q;
  logic                  udf_q;

  op_e                   op;
  logic [PTR_W-1:0]      cur_tp;
  logic [PTR_W-1:0]      top_idx;
  logic [CNT_W-1:0]      cur_cnt;
  logic [DATA_WIDTH-1:0] top_val;
  logic                  cur_full;
  logic                  cur_empty;
  logic                  mem_we;

  always_comb begin
    cur_tp    = tp_q[bus.ctx];
    cur_cnt   = cnt_q[bus.ctx];
    top_idx   = cur_tp - 1'b1;
    top_val   = mem_q[bus.ctx][top_idx];
    cur_full  = (cur_cnt == CNT_W'(DEPTH));
    cur_empty = (cur_cnt == '0);
  end

  // A pending or just-cleared mismatch blocks every op; push > ret > pop.
  always_comb begin
    op = OP_NONE;
    if (bus.ena && !mismatch_q && !bus.clr_mismatch) begin
      if (bus.push)     op = OP_PUSH;
      else if (bus.ret) op = OP_RET;
      else if (bus.pop) op = OP_POP;
    end
  end

`ifdef RAS_OVF_WRAP_EN
  assign mem_we = !rst_i && (op == OP_PUSH);
`else
  assign mem_we = !rst_i && (op == OP_PUSH) && !cur_full;
`endif

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[bus.ctx][cur_tp] <= bus.din;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NCTX; i++) begin
        tp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      mismatch_q <= 1'b0;
      mis_ctx_q  <= '0;
      mis_addr_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      if (bus.clr_mismatch) mismatch_q <= 1'b0;
      unique case (op)
        OP_PUSH: begin
          if (!cur_full) begin
            tp_q[bus.ctx]  <= cur_tp + 1'b1;
            cnt_q[bus.ctx] <= cur_cnt + 1'b1;
          end else begin
            ovf_q <= 1'b1;
`ifdef RAS_OVF_WRAP_EN
            tp_q[bus.ctx] <= cur_tp + 1'b1;
`endif
          end
        end
        OP_RET, OP_POP: begin
          if (cur_empty) begin
            udf_q <= 1'b1;
          end else begin
            tp_q[bus.ctx]  <= top_idx;
            cnt_q[bus.ctx] <= cur_cnt - 1'b1;
            if (op == OP_RET && top_val != bus.din) begin
              mismatch_q <= 1'b1;
              mis_ctx_q  <= bus.ctx;
              mis_addr_q <= top_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout     = cur_empty ? '0 : top_val;
  assign bus.count    = cur_cnt;
  assign bus.full     = cur_full;
  assign bus.empty    = cur_empty;
  assign bus.mismatch = mismatch_q;
  assign bus.mis_ctx  = mis_ctx_q;
  assign bus.mis_addr = mis_addr_q;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
endmodule
